// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
//
// Single-port memory arbiter shared by the instruction-fetch stage and the
// load/store path. At most one requester is granted per cycle. Data wins
// over fetch, except that after STARVE_MAX consecutive data grants taken
// while fetch was eligible, fetch is granted once. Each read grant launches
// a tag down a MEM_LAT-deep pipeline that steers the memory read data back
// to the requester that issued it.
//
// Handshake: a requester raises *_req and holds it (with its address/data
// stable) until it sees *_gnt high in the same cycle; the access is taken
// in the cycle where req and gnt are both high. Read responses have no
// back-pressure: *_rvalid is a one-cycle pulse and *_rdata holds its value
// until the next pulse.
//
// Ports
//   ck, rst_n                clock, asynchronous active-low reset
//   if_req/if_addr           fetch request and word address
//   if_gnt                   fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata       fetch response (registered pulse / held data)
//   if_flush                 drop in-flight fetch responses, block fetch grant
//   halt                     block fetch grants while high
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 store, 0 load)
//   d_gnt                    data accepted this cycle (combinational)
//   d_rvalid/d_rdata         load response (registered pulse / held data)
//   mem_en/mem_we/mem_addr/mem_wdata  memory command
//   mem_rdata                memory read data, MEM_LAT cycles after mem_en
//   busy                     at least one read in flight
// -----------------------------------------------------------------------------
module mem_arb #(
  parameter int AW         = 9,
  parameter int DW         = 24,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          ck,
  input  logic          rst_n,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          if_flush,
  input  logic          halt,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // status
  output logic          busy
);

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  // Tag source encoding: 1 = fetch, 0 = data.
  localparam logic SRC_FETCH = 1'b1;
  localparam logic SRC_DATA  = 1'b0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0]         starve_cnt_q, starve_cnt_d;
  logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0] tag_src_q, tag_src_d;
  logic               if_rvalid_q, if_rvalid_d;
  logic               d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]      if_rdata_q, d_rdata_q;

  // ---------------------------------------------------------------------------
  // Grant logic
  // ---------------------------------------------------------------------------
  logic fetch_ok;
  logic starve_hit;
  logic rd_grant;

  assign fetch_ok   = if_req & ~halt & ~if_flush;
  // Fetch has waited through STARVE_MAX data grants: it takes this cycle.
  assign starve_hit = fetch_ok & (starve_cnt_q == STARVE_MAX_C);
  assign d_gnt      = d_req & ~starve_hit;
  assign if_gnt     = fetch_ok & ~d_gnt;
  assign rd_grant   = if_gnt | (d_gnt & ~d_we);

  // ---------------------------------------------------------------------------
  // Memory command mux
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_wdata = d_wdata;
      end
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!fetch_ok || if_gnt) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != STARVE_MAX_C)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline and response steering
  // ---------------------------------------------------------------------------
  logic last_vld;
  logic last_src;

  assign last_vld = tag_vld_q[MEM_LAT-1];
  assign last_src = tag_src_q[MEM_LAT-1];

  always_comb begin
    tag_vld_d    = '0;
    tag_src_d    = '0;
    tag_vld_d[0] = rd_grant;
    tag_src_d[0] = if_gnt ? SRC_FETCH : SRC_DATA;
    // A flush kills fetch tags as they advance; load tags pass through.
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1] & ~(if_flush & (tag_src_q[i-1] == SRC_FETCH));
      tag_src_d[i] = tag_src_q[i-1];
    end
    // The exiting fetch tag is also suppressed by a flush in this cycle.
    if_rvalid_d = last_vld & (last_src == SRC_FETCH) & ~if_flush;
    d_rvalid_d  = last_vld & (last_src == SRC_DATA);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      tag_vld_q    <= '0;
      tag_src_q    <= '0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_vld_q    <= tag_vld_d;
      tag_src_q    <= tag_src_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  // Response data registers only load on a delivered response and otherwise
  // hold the last value.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_rvalid_d) begin
        if_rdata_q <= mem_rdata;
      end
      if (d_rvalid_d) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb
//
// Bench for mem_arb with MEM_LAT=3, STARVE_MAX=4. Contains a behavioural
// memory, a reference model holding outstanding responses as a queue of
// {due cycle, source, data}, a grant vector table, hand-written sequences
// for reset, store/load, flush and async reset, and a randomized phase.
// -----------------------------------------------------------------------------
module tb_mem_arb;

  localparam int AW  = 9;
  localparam int DW  = 24;
  localparam int LAT = 3;
  localparam int SM  = 4;
  localparam int MEM_WORDS = 1 << AW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic ck    = 1'b0;
  logic rst_n = 1'b0;
  always #5 ck = ~ck;

  // DUT signals
  logic          if_req, if_flush, halt;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;

  mem_arb #(
    .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SM)
  ) dut (
    .ck(ck), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .if_flush(if_flush), .halt(halt),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // ---------------------------------------------------------------------------
  // Behavioural memory: fixed initial contents, write-first, LAT read latency
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 0) return 24'h40_1041;
    return DW'((a * 40503) ^ 32'h5A5A5A);
  endfunction

  logic [DW-1:0] mem_arr     [MEM_WORDS];
  bit            mem_written [MEM_WORDS];
  logic [DW-1:0] rd_pipe     [LAT];

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    return mem_written[a] ? mem_arr[a] : init_word(int'(a));
  endfunction

  always @(posedge ck) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr]     <= mem_wdata;
      mem_written[mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_read(mem_addr) : '0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // ---------------------------------------------------------------------------
  // Reference model state and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int            due;
    bit            is_f;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         pend[$];
  logic [DW-1:0] shadow [MEM_WORDS];
  int            sc;
  int            cyc;
  logic [DW-1:0] last_if, last_d;
  int            checks;
  int            failures;

  // Values sampled at the last negedge, for the hand-written checks.
  logic          s_if_gnt, s_d_gnt, s_if_rvalid, s_d_rvalid, s_mem_we;
  logic [DW-1:0] s_if_rdata, s_d_rdata;

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0b expected=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%06h expected=%06h", name, cyc, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    sc      = 0;
    last_if = '0;
    last_d  = '0;
  endtask

  // One clock cycle: inputs are already driven; check at the negedge, advance
  // the model, then return just after the next rising edge.
  task automatic run_cycle();
    bit            fok, mdg, mig, eiv, edv, ebusy;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    resp_t         keep[$];
    resp_t         r;
    @(negedge ck);
    fok = if_req && !halt && !if_flush;
    mdg = d_req && !(fok && sc == SM);
    mig = fok && !mdg;
    ea  = mdg ? d_addr : (mig ? if_addr : '0);
    ew  = (mdg && d_we) ? d_wdata : '0;
    chkb("if_gnt", if_gnt, mig);
    chkb("d_gnt", d_gnt, mdg);
    chkb("mem_en", mem_en, mig | mdg);
    chkb("mem_we", mem_we, mdg & d_we);
    chka("mem_addr", mem_addr, ea);
    chkw("mem_wdata", mem_wdata, ew);
    eiv   = 1'b0;
    edv   = 1'b0;
    ebusy = 1'b0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        if (pend[i].is_f) begin
          eiv     = 1'b1;
          last_if = pend[i].data;
        end else begin
          edv    = 1'b1;
          last_d = pend[i].data;
        end
      end
      if (pend[i].due > cyc) ebusy = 1'b1;
    end
    chkb("if_rvalid", if_rvalid, eiv);
    chkb("d_rvalid", d_rvalid, edv);
    chkw("if_rdata", if_rdata, last_if);
    chkw("d_rdata", d_rdata, last_d);
    chkb("busy", busy, ebusy);
    s_if_gnt    = if_gnt;
    s_d_gnt     = d_gnt;
    s_if_rvalid = if_rvalid;
    s_d_rvalid  = d_rvalid;
    s_mem_we    = mem_we;
    s_if_rdata  = if_rdata;
    s_d_rdata   = d_rdata;
    // Retire delivered responses; a flush drops every pending fetch response.
    foreach (pend[i]) begin
      if (pend[i].due > cyc && !(if_flush && pend[i].is_f)) keep.push_back(pend[i]);
    end
    pend = keep;
    if (mdg && d_we) shadow[d_addr] = d_wdata;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (mig) begin
        r.due = cyc + LAT + 1; r.is_f = 1'b1; r.data = shadow[if_addr];
        pend.push_back(r);
      end
      if (mdg && !d_we) begin
        r.due = cyc + LAT + 1; r.is_f = 1'b0; r.data = shadow[d_addr];
        pend.push_back(r);
      end
      if (!fok || mig) sc = 0;
      else if (mdg && sc < SM) sc = sc + 1;
    end
    cyc++;
    @(posedge ck);
    #1;
  endtask

  task automatic idle_inputs();
    if_req   = 1'b0;
    if_addr  = '0;
    if_flush = 1'b0;
    halt     = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Grant vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit d_req;
    bit d_we;
    bit if_req;
    bit halt;
    bit flush;
    bit exp_ig;
    bit exp_dg;
  } vec_t;

  function automatic vec_t mk(input bit dr, input bit we, input bit fr, input bit h,
                              input bit fl, input bit eig, input bit edg);
    vec_t v;
    v.d_req = dr; v.d_we = we; v.if_req = fr; v.halt = h; v.flush = fl;
    v.exp_ig = eig; v.exp_dg = edg;
    return v;
  endfunction

  vec_t vt[20];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t0;
    int we_cnt;
    int rv_cnt;

    checks   = 0;
    failures = 0;
    cyc      = 0;
    for (int i = 0; i < MEM_WORDS; i++) shadow[i] = init_word(i);
    model_reset();
    idle_inputs();

    // Contention: 4 data, 1 fetch, 4 data, 1 fetch.
    for (int i = 0; i < 10; i++) vt[i] = mk(1, 0, 1, 0, 0, (i == 4 || i == 9), !(i == 4 || i == 9));
    // Halt blocks fetch but not data; fetch follows as soon as halt drops.
    for (int i = 10; i < 13; i++) vt[i] = mk(1, 0, 1, 1, 0, 0, 1);
    vt[13] = mk(0, 0, 1, 1, 0, 0, 0);
    vt[14] = mk(0, 0, 1, 1, 0, 0, 0);
    vt[15] = mk(0, 0, 1, 0, 0, 1, 0);
    // Flush blocks the fetch grant; data unaffected.
    vt[16] = mk(1, 0, 1, 0, 1, 0, 1);
    vt[17] = mk(0, 0, 1, 0, 1, 0, 0);
    vt[18] = mk(0, 0, 0, 0, 0, 0, 0);
    vt[19] = mk(1, 1, 0, 0, 0, 0, 1);

    // --- Reset: registered outputs held at zero ---
    run_cycle();
    run_cycle();
    chkb("reset_if_rvalid", s_if_rvalid, 1'b0);
    chkw("reset_d_rdata", s_d_rdata, '0);
    rst_n = 1'b1;

    // --- First fetch after reset: grant now, data LAT+1 cycles later ---
    if_req  = 1'b1;
    if_addr = '0;
    run_cycle();
    chkb("first_fetch_gnt", s_if_gnt, 1'b1);
    idle_inputs();
    for (int i = 0; i < LAT; i++) begin
      run_cycle();
      chkb("first_fetch_early", s_if_rvalid, 1'b0);
    end
    run_cycle();
    chkb("first_fetch_rvalid", s_if_rvalid, 1'b1);
    chkw("first_fetch_rdata", s_if_rdata, 24'h40_1041);

    // --- Store then load to the same address ---
    we_cnt = 0;
    rv_cnt = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'd7; d_wdata = 24'h00_0005;
    run_cycle();
    chkb("sw_gnt", s_d_gnt, 1'b1);
    we_cnt += int'(s_mem_we);
    d_we = 1'b0;
    run_cycle();
    chkb("lw_gnt", s_d_gnt, 1'b1);
    we_cnt += int'(s_mem_we);
    idle_inputs();
    for (int i = 0; i < LAT; i++) begin
      run_cycle();
      rv_cnt += int'(s_d_rvalid);
      we_cnt += int'(s_mem_we);
    end
    chkb("sw_no_rvalid", (rv_cnt == 0), 1'b1);
    run_cycle();
    chkb("lw_rvalid", s_d_rvalid, 1'b1);
    chkw("lw_rdata", s_d_rdata, 24'h00_0005);
    chkb("sw_one_we_pulse", (we_cnt == 1), 1'b1);

    // --- Grant vector table ---
    for (int i = 0; i < 20; i++) begin
      d_req   = vt[i].d_req;
      d_we    = vt[i].d_we;
      d_addr  = AW'(100 + i);
      d_wdata = DW'($urandom);
      if_req  = vt[i].if_req;
      if_addr = AW'(200 + i);
      halt    = vt[i].halt;
      if_flush = vt[i].flush;
      run_cycle();
      chkb($sformatf("vec%0d_if_gnt", i), s_if_gnt, vt[i].exp_ig);
      chkb($sformatf("vec%0d_d_gnt", i), s_d_gnt, vt[i].exp_dg);
    end
    idle_inputs();
    for (int i = 0; i < LAT + 2; i++) run_cycle();

    // --- Flush: fetches in cycles 0..2, flush plus a load in cycle 3 ---
    for (int i = 0; i < 3; i++) begin
      if_req  = 1'b1;
      if_addr = AW'(10 + i);
      run_cycle();
      chkb("flush_fetch_gnt", s_if_gnt, 1'b1);
    end
    idle_inputs();
    if_flush = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'd20;
    run_cycle();
    chkb("flush_load_gnt", s_d_gnt, 1'b1);
    idle_inputs();
    for (int i = 0; i < LAT; i++) begin
      run_cycle();
      chkb("flush_no_if_rvalid", s_if_rvalid, 1'b0);
    end
    run_cycle();
    chkb("flush_load_rvalid", s_d_rvalid, 1'b1);
    chkw("flush_load_rdata", s_d_rdata, init_word(20));

    // --- Async reset between a load grant and its response ---
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'd30;
    run_cycle();
    idle_inputs();
    run_cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chkb("async_rst_busy", busy, 1'b0);
    chkb("async_rst_d_rvalid", d_rvalid, 1'b0);
    for (int i = 0; i < LAT + 2; i++) begin
      run_cycle();
      chkb("async_rst_no_resp", s_d_rvalid, 1'b0);
    end
    rst_n = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'd30;
    run_cycle();
    idle_inputs();
    for (int i = 0; i < LAT; i++) run_cycle();
    run_cycle();
    chkb("after_rst_load_rvalid", s_d_rvalid, 1'b1);
    chkw("after_rst_load_rdata", s_d_rdata, init_word(30));

    // --- Randomized traffic; requests held until granted ---
    s_if_gnt = 1'b1;
    s_d_gnt  = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if (!if_req || s_if_gnt) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = AW'($urandom_range(0, 300));
      end
      if (!d_req || s_d_gnt) begin
        d_req   = ($urandom_range(0, 99) < 55);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = AW'($urandom_range(0, 300));
        d_wdata = DW'($urandom);
      end
      halt     = ($urandom_range(0, 9) == 0);
      if_flush = ($urandom_range(0, 14) == 0);
      run_cycle();
    end
    idle_inputs();
    for (int i = 0; i < LAT + 2; i++) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
